// File: rtl/rob_nway.sv
// N-wide reorder buffer: in-order allocate, out-of-order completion, in-order retire.
// A mispredicting branch in any retire slot closes its group and squashes every younger entry.
module rob_nway #(
  parameter int ROB_IDX = 5,
  parameter int WIDTH   = 2,
  parameter int PRF_IDX = 6,
  parameter int ARF_IDX = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  din_req,
  input  logic [WIDTH-1:0][31:0]            ir_in,
  input  logic [WIDTH-1:0][63:0]            npc_in,
  input  logic [WIDTH-1:0][PRF_IDX-1:0]     pdest_in,
  input  logic [WIDTH-1:0][ARF_IDX-1:0]     adest_in,
  input  logic [WIDTH-1:0]                  isbranch_in,
  input  logic [WIDTH-1:0]                  bt_pd_in,
  input  logic [WIDTH-1:0][63:0]            ba_pd_in,
  input  logic [WIDTH-1:0]                  illegal_in,
  output logic [WIDTH-1:0]                  din_gnt,
  output logic [WIDTH-1:0][ROB_IDX-1:0]     rob_idx_out,
  input  logic [WIDTH-1:0]                  dup_req,
  input  logic [WIDTH-1:0][ROB_IDX-1:0]     rob_idx_in,
  input  logic [WIDTH-1:0]                  bt_ex_in,
  input  logic [WIDTH-1:0][63:0]            ba_ex_in,
  output logic [WIDTH-1:0]                  dout_valid,
  output logic [WIDTH-1:0][31:0]            ir_out,
  output logic [WIDTH-1:0][63:0]            npc_out,
  output logic [WIDTH-1:0][PRF_IDX-1:0]     pdest_out,
  output logic [WIDTH-1:0][ARF_IDX-1:0]     adest_out,
  output logic [WIDTH-1:0]                  illegal_out,
  output logic [WIDTH-1:0]                  isbranch_out,
  output logic [WIDTH-1:0]                  bt_out,
  output logic [WIDTH-1:0][63:0]            ba_out,
  output logic                              branch_miss,
  output logic [63:0]                       correct_target,
  output logic [ROB_IDX-1:0]                head,
  output logic [ROB_IDX:0]                  free_cnt
);
  localparam int ROB_SZ = 1 << ROB_IDX;
  localparam int CW     = ROB_IDX + 1;

  logic [ROB_IDX-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d, free_q, free_d;
  logic [CW-1:0]      retire_cnt_s, grant_cnt_s;
  logic [WIDTH-1:0][ROB_IDX-1:0] ret_idx_s;
  logic               ret_chain_s, req_chain_s, mis_s;

  logic [ROB_SZ-1:0]  valid_q, rdy_q, isbr_q, btpd_q, btex_q, ill_q;
  logic [31:0]        ir_q   [ROB_SZ];
  logic [63:0]        npc_q  [ROB_SZ];
  logic [63:0]        bapd_q [ROB_SZ];
  logic [63:0]        baex_q [ROB_SZ];
  logic [PRF_IDX-1:0] pdest_q[ROB_SZ];
  logic [ARF_IDX-1:0] adest_q[ROB_SZ];

  function automatic logic mispredict(input logic isbr, input logic btex, input logic btpd,
                                      input logic [63:0] baex, input logic [63:0] bapd);
    return isbr && ((btex != btpd) || (btex && (baex != bapd)));
  endfunction

  assign head     = head_q;
  assign free_cnt = free_q;

  // Retire group: contiguous ready prefix from head, closed by a mispredict or illegal entry.
  always_comb begin
    dout_valid     = '0;
    ir_out         = '0;
    npc_out        = '0;
    pdest_out      = '0;
    adest_out      = '0;
    illegal_out    = '0;
    isbranch_out   = '0;
    bt_out         = '0;
    ba_out         = '0;
    branch_miss    = 1'b0;
    correct_target = 64'd0;
    retire_cnt_s   = '0;
    ret_idx_s      = '0;
    ret_chain_s    = 1'b1;
    mis_s          = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      ret_idx_s[k] = head_q + ROB_IDX'(k);
      mis_s = mispredict(isbr_q[ret_idx_s[k]], btex_q[ret_idx_s[k]], btpd_q[ret_idx_s[k]],
                         baex_q[ret_idx_s[k]], bapd_q[ret_idx_s[k]]);
      if (ret_chain_s && (CW'(k) < count_q) && valid_q[ret_idx_s[k]] && rdy_q[ret_idx_s[k]]) begin
        dout_valid[k]   = 1'b1;
        retire_cnt_s    = retire_cnt_s + CW'(1);
        ir_out[k]       = ir_q[ret_idx_s[k]];
        npc_out[k]      = npc_q[ret_idx_s[k]];
        pdest_out[k]    = pdest_q[ret_idx_s[k]];
        adest_out[k]    = adest_q[ret_idx_s[k]];
        illegal_out[k]  = ill_q[ret_idx_s[k]];
        isbranch_out[k] = isbr_q[ret_idx_s[k]];
        bt_out[k]       = btex_q[ret_idx_s[k]];
        ba_out[k]       = baex_q[ret_idx_s[k]];
        if (mis_s) begin
          branch_miss    = 1'b1;
          correct_target = btex_q[ret_idx_s[k]] ? baex_q[ret_idx_s[k]] : npc_q[ret_idx_s[k]];
        end else begin
          correct_target = correct_target;
        end
        ret_chain_s = !mis_s && !ill_q[ret_idx_s[k]];
      end else begin
        ret_chain_s = 1'b0;
      end
    end
  end

  // Dispatch grant uses the registered free count, so same-cycle retirement is not credited.
  always_comb begin
    din_gnt     = '0;
    rob_idx_out = '0;
    grant_cnt_s = '0;
    req_chain_s = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      rob_idx_out[k] = tail_q + ROB_IDX'(k);
      req_chain_s    = req_chain_s & din_req[k];
      if (req_chain_s && (CW'(k + 1) <= free_q) && !branch_miss) begin
        din_gnt[k]  = 1'b1;
        grant_cnt_s = grant_cnt_s + CW'(1);
      end else begin
        din_gnt[k] = 1'b0;
      end
    end
  end

  // Pointer and occupancy next-state; a flush collapses tail onto the advanced head.
  always_comb begin
    head_d = head_q + retire_cnt_s[ROB_IDX-1:0];
    if (branch_miss) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      tail_d  = tail_q + grant_cnt_s[ROB_IDX-1:0];
      count_d = count_q + grant_cnt_s - retire_cnt_s;
    end
    free_d = CW'(ROB_SZ) - count_d;
  end

  // State update: completions, then allocations, then retirement clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CW'(ROB_SZ);
      valid_q <= '0;
      rdy_q   <= '0;
      btex_q  <= '0;
      for (int i = 0; i < ROB_SZ; i++) baex_q[i] <= 64'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
      if (branch_miss) begin
        valid_q <= '0;
        rdy_q   <= '0;
      end else begin
        for (int j = 0; j < WIDTH; j++) begin
          if (dup_req[j] && valid_q[rob_idx_in[j]]) begin
            btex_q[rob_idx_in[j]] <= bt_ex_in[j];
            baex_q[rob_idx_in[j]] <= ba_ex_in[j];
            rdy_q[rob_idx_in[j]]  <= 1'b1;
          end
        end
        for (int k = 0; k < WIDTH; k++) begin
          if (din_gnt[k]) begin
            valid_q[rob_idx_out[k]] <= 1'b1;
            rdy_q[rob_idx_out[k]]   <= illegal_in[k];
            btex_q[rob_idx_out[k]]  <= 1'b0;
            baex_q[rob_idx_out[k]]  <= 64'd0;
            isbr_q[rob_idx_out[k]]  <= isbranch_in[k];
            btpd_q[rob_idx_out[k]]  <= bt_pd_in[k];
            ill_q[rob_idx_out[k]]   <= illegal_in[k];
            ir_q[rob_idx_out[k]]    <= ir_in[k];
            npc_q[rob_idx_out[k]]   <= npc_in[k];
            bapd_q[rob_idx_out[k]]  <= ba_pd_in[k];
            pdest_q[rob_idx_out[k]] <= pdest_in[k];
            adest_q[rob_idx_out[k]] <= adest_in[k];
          end
        end
        for (int k = 0; k < WIDTH; k++) begin
          if (dout_valid[k]) begin
            valid_q[ret_idx_s[k]] <= 1'b0;
            rdy_q[ret_idx_s[k]]   <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: directed scenarios with fixed expectations, then random traffic
// checked against a queue-based model of program-order entries.
module tb_rob_nway;
  localparam int RI = 5, W = 2, PI = 6, AI = 5, SZ = 32;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] din_req, isbranch_in, bt_pd_in, illegal_in, din_gnt, dup_req, bt_ex_in;
  logic [W-1:0] dout_valid, illegal_out, isbranch_out, bt_out;
  logic [W-1:0][31:0] ir_in, ir_out;
  logic [W-1:0][63:0] npc_in, ba_pd_in, ba_ex_in, npc_out, ba_out;
  logic [W-1:0][PI-1:0] pdest_in, pdest_out;
  logic [W-1:0][AI-1:0] adest_in, adest_out;
  logic [W-1:0][RI-1:0] rob_idx_out, rob_idx_in;
  logic branch_miss;
  logic [63:0] correct_target;
  logic [RI-1:0] head;
  logic [RI:0] free_cnt;

  int checks = 0;
  int failures = 0;

  rob_nway #(.ROB_IDX(RI), .WIDTH(W), .PRF_IDX(PI), .ARF_IDX(AI)) dut (
    .clk(clk), .reset(reset), .din_req(din_req), .ir_in(ir_in), .npc_in(npc_in),
    .pdest_in(pdest_in), .adest_in(adest_in), .isbranch_in(isbranch_in), .bt_pd_in(bt_pd_in),
    .ba_pd_in(ba_pd_in), .illegal_in(illegal_in), .din_gnt(din_gnt), .rob_idx_out(rob_idx_out),
    .dup_req(dup_req), .rob_idx_in(rob_idx_in), .bt_ex_in(bt_ex_in), .ba_ex_in(ba_ex_in),
    .dout_valid(dout_valid), .ir_out(ir_out), .npc_out(npc_out), .pdest_out(pdest_out),
    .adest_out(adest_out), .illegal_out(illegal_out), .isbranch_out(isbranch_out),
    .bt_out(bt_out), .ba_out(ba_out), .branch_miss(branch_miss), .correct_target(correct_target),
    .head(head), .free_cnt(free_cnt));

  always #5 clk = ~clk;

  typedef struct {
    int idx; logic [31:0] ir; logic [63:0] npc; logic [63:0] bapd; logic [63:0] baex;
    bit isbr; bit btpd; bit ill; bit rdy; bit btex;
  } ent_t;
  ent_t mq[$];
  int m_head, m_tail, e_ret;
  logic [W-1:0] e_dv, e_gnt;
  logic e_bm;
  logic [63:0] e_ct;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    din_req = '0; ir_in = '0; npc_in = '0; pdest_in = '0; adest_in = '0;
    isbranch_in = '0; bt_pd_in = '0; ba_pd_in = '0; illegal_in = '0;
    dup_req = '0; rob_idx_in = '0; bt_ex_in = '0; ba_ex_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    mq.delete(); m_head = 0; m_tail = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks += 6;
    if (free_cnt !== 6'd32) begin failures++; $display("FAIL reset_free got=%0d exp=32", free_cnt); end
    if (head !== 5'd0) begin failures++; $display("FAIL reset_head got=%0d exp=0", head); end
    if (dout_valid !== 2'b00) begin failures++; $display("FAIL reset_dv got=%b exp=00", dout_valid); end
    if (rob_idx_out[0] !== 5'd0 || rob_idx_out[1] !== 5'd1) begin
      failures++; $display("FAIL reset_idx got=%0d,%0d exp=0,1", rob_idx_out[0], rob_idx_out[1]); end
    if (branch_miss !== 1'b0) begin failures++; $display("FAIL reset_bm got=%b exp=0", branch_miss); end
    if (correct_target !== 64'd0) begin failures++; $display("FAIL reset_ct got=%h exp=0", correct_target); end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      din_req = 2'b11; ir_in[0] = $urandom(); ir_in[1] = $urandom();
      #2;
      checks += 3;
      if (din_gnt !== 2'b11) begin failures++; $display("FAIL fill_gnt i=%0d got=%b exp=11", i, din_gnt); end
      if (free_cnt !== 6'(32 - 2 * i)) begin
        failures++; $display("FAIL fill_free i=%0d got=%0d exp=%0d", i, free_cnt, 32 - 2 * i); end
      if (rob_idx_out[0] !== 5'(2 * i)) begin
        failures++; $display("FAIL fill_idx i=%0d got=%0d exp=%0d", i, rob_idx_out[0], 2 * i); end
      tick();
    end
    din_req = 2'b11;
    #2;
    checks += 3;
    if (free_cnt !== 6'd0) begin failures++; $display("FAIL full_free got=%0d exp=0", free_cnt); end
    if (din_gnt !== 2'b00) begin failures++; $display("FAIL full_gnt got=%b exp=00", din_gnt); end
    if (rob_idx_out[0] !== 5'd0) begin failures++; $display("FAIL full_wrap got=%0d exp=0", rob_idx_out[0]); end
    tick();
  endtask

  task automatic test_out_of_order();
    clear_inputs();
    dup_req = 2'b01; rob_idx_in[0] = 5'd1;
    #2; checks++;
    if (dout_valid !== 2'b00) begin failures++; $display("FAIL ooo_c0 got=%b exp=00", dout_valid); end
    tick();
    rob_idx_in[0] = 5'd0;
    #2; checks++;
    if (dout_valid !== 2'b00) begin failures++; $display("FAIL ooo_c1 got=%b exp=00", dout_valid); end
    tick();
    dup_req = 2'b00; din_req = 2'b11;
    #2; checks += 3;
    if (dout_valid !== 2'b11) begin failures++; $display("FAIL ooo_c2 got=%b exp=11", dout_valid); end
    if (branch_miss !== 1'b0) begin failures++; $display("FAIL ooo_bm got=%b exp=0", branch_miss); end
    if (din_gnt !== 2'b00) begin failures++; $display("FAIL ooo_full_gnt got=%b exp=00", din_gnt); end
    tick();
    din_req = 2'b00;
    #2; checks += 2;
    if (head !== 5'd2) begin failures++; $display("FAIL ooo_head got=%0d exp=2", head); end
    if (free_cnt !== 6'd2) begin failures++; $display("FAIL ooo_free got=%0d exp=2", free_cnt); end
  endtask

  task automatic test_branch_slot1();
    do_reset();
    din_req = 2'b11; isbranch_in = 2'b10; npc_in[1] = 64'h44;
    tick();
    isbranch_in = 2'b00; dup_req = 2'b11;
    rob_idx_in[0] = 5'd0; rob_idx_in[1] = 5'd1; bt_ex_in = 2'b10; ba_ex_in[1] = 64'h1000;
    tick();
    dup_req = 2'b01; rob_idx_in[0] = 5'd2; bt_ex_in = 2'b00;
    #2; checks += 4;
    if (dout_valid !== 2'b11) begin failures++; $display("FAIL br1_dv got=%b exp=11", dout_valid); end
    if (branch_miss !== 1'b1) begin failures++; $display("FAIL br1_bm got=%b exp=1", branch_miss); end
    if (correct_target !== 64'h1000) begin failures++; $display("FAIL br1_ct got=%h exp=1000", correct_target); end
    if (din_gnt !== 2'b00) begin failures++; $display("FAIL br1_gnt got=%b exp=00", din_gnt); end
    tick();
    clear_inputs();
    #2; checks += 4;
    if (free_cnt !== 6'd32) begin failures++; $display("FAIL br1_free got=%0d exp=32", free_cnt); end
    if (head !== 5'd2) begin failures++; $display("FAIL br1_head got=%0d exp=2", head); end
    if (rob_idx_out[0] !== 5'd2) begin failures++; $display("FAIL br1_tail got=%0d exp=2", rob_idx_out[0]); end
    if (dout_valid !== 2'b00) begin failures++; $display("FAIL br1_after_dv got=%b exp=00", dout_valid); end
  endtask

  task automatic test_branch_slot0();
    din_req = 2'b11; isbranch_in = 2'b01; bt_pd_in = 2'b01; ba_pd_in[0] = 64'h2000;
    tick();
    isbranch_in = 2'b00; bt_pd_in = 2'b00; dup_req = 2'b11;
    rob_idx_in[0] = 5'd2; bt_ex_in = 2'b01; ba_ex_in[0] = 64'h2040; rob_idx_in[1] = 5'd3;
    tick();
    dup_req = 2'b01; rob_idx_in[0] = 5'd4; bt_ex_in = 2'b00;
    #2; checks += 4;
    if (dout_valid !== 2'b01) begin failures++; $display("FAIL br0_dv got=%b exp=01", dout_valid); end
    if (branch_miss !== 1'b1) begin failures++; $display("FAIL br0_bm got=%b exp=1", branch_miss); end
    if (correct_target !== 64'h2040) begin failures++; $display("FAIL br0_ct got=%h exp=2040", correct_target); end
    if (din_gnt !== 2'b00) begin failures++; $display("FAIL br0_gnt got=%b exp=00", din_gnt); end
    tick();
    clear_inputs();
    #2; checks += 3;
    if (head !== 5'd3) begin failures++; $display("FAIL br0_head got=%0d exp=3", head); end
    if (free_cnt !== 6'd32) begin failures++; $display("FAIL br0_free got=%0d exp=32", free_cnt); end
    if (rob_idx_out[0] !== 5'd3) begin failures++; $display("FAIL br0_tail got=%0d exp=3", rob_idx_out[0]); end
  endtask

  task automatic test_illegal();
    din_req = 2'b11; illegal_in = 2'b01;
    tick();
    clear_inputs();
    #2; checks += 4;
    if (dout_valid !== 2'b01) begin failures++; $display("FAIL ill_dv got=%b exp=01", dout_valid); end
    if (illegal_out[0] !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b exp=1", illegal_out[0]); end
    if (branch_miss !== 1'b0) begin failures++; $display("FAIL ill_bm got=%b exp=0", branch_miss); end
    if (head !== 5'd3) begin failures++; $display("FAIL ill_head0 got=%0d exp=3", head); end
    tick();
    #2; checks += 3;
    if (head !== 5'd4) begin failures++; $display("FAIL ill_head1 got=%0d exp=4", head); end
    if (free_cnt !== 6'd31) begin failures++; $display("FAIL ill_free got=%0d exp=31", free_cnt); end
    if (dout_valid !== 2'b00) begin failures++; $display("FAIL ill_dv1 got=%b exp=00", dout_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 31; i++) begin
      din_req = 2'b01; illegal_in = 2'b01;
      tick();
    end
    din_req = 2'b11; illegal_in = 2'b11;
    #2; checks += 3;
    if (rob_idx_out[0] !== 5'd31 || rob_idx_out[1] !== 5'd0) begin
      failures++; $display("FAIL wrap_idx got=%0d,%0d exp=31,0", rob_idx_out[0], rob_idx_out[1]); end
    if (din_gnt !== 2'b11) begin failures++; $display("FAIL wrap_gnt got=%b exp=11", din_gnt); end
    if (dout_valid !== 2'b01) begin failures++; $display("FAIL wrap_dv got=%b exp=01", dout_valid); end
    tick();
    clear_inputs();
    #2; checks += 2;
    if (head !== 5'd31) begin failures++; $display("FAIL wrap_head31 got=%0d exp=31", head); end
    if (dout_valid !== 2'b01) begin failures++; $display("FAIL wrap_dv31 got=%b exp=01", dout_valid); end
    tick();
    #2; checks++;
    if (head !== 5'd0) begin failures++; $display("FAIL wrap_head0 got=%0d exp=0", head); end
    tick();
    #2; checks += 2;
    if (head !== 5'd1) begin failures++; $display("FAIL wrap_head1 got=%0d exp=1", head); end
    if (free_cnt !== 6'd32) begin failures++; $display("FAIL wrap_free got=%0d exp=32", free_cnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      din_req = 2'b11;
      tick();
    end
    #2; checks++;
    if (free_cnt !== 6'd22) begin failures++; $display("FAIL rstmid_pre got=%0d exp=22", free_cnt); end
    reset = 1'b1; din_req = 2'b11; dup_req = 2'b11; rob_idx_in[0] = 5'd1; rob_idx_in[1] = 5'd2;
    tick();
    reset = 1'b0; clear_inputs();
    #2; checks += 4;
    if (free_cnt !== 6'd32) begin failures++; $display("FAIL rstmid_free got=%0d exp=32", free_cnt); end
    if (dout_valid !== 2'b00) begin failures++; $display("FAIL rstmid_dv got=%b exp=00", dout_valid); end
    if (head !== 5'd0) begin failures++; $display("FAIL rstmid_head got=%0d exp=0", head); end
    if (rob_idx_out[0] !== 5'd0) begin failures++; $display("FAIL rstmid_tail got=%0d exp=0", rob_idx_out[0]); end
  endtask

  // Model: expected outputs of the current cycle from the program-order queue.
  task automatic model_expect();
    bit mis, reqok;
    int freen;
    e_dv = '0; e_gnt = '0; e_bm = 1'b0; e_ct = 64'd0; e_ret = 0;
    for (int k = 0; k < W; k++) begin
      if (k >= mq.size() || !mq[k].rdy) break;
      e_dv[k] = 1'b1; e_ret++;
      mis = mq[k].isbr && (mq[k].btex != mq[k].btpd || (mq[k].btex && mq[k].baex != mq[k].bapd));
      if (mis) begin e_bm = 1'b1; e_ct = mq[k].btex ? mq[k].baex : mq[k].npc; end
      if (mis || mq[k].ill) break;
    end
    freen = SZ - mq.size();
    reqok = 1'b1;
    for (int k = 0; k < W; k++) begin
      reqok = reqok && din_req[k];
      e_gnt[k] = reqok && (k + 1 <= freen) && !e_bm;
    end
  endtask

  task automatic model_commit();
    ent_t e;
    for (int r = 0; r < e_ret; r++) void'(mq.pop_front());
    m_head = (m_head + e_ret) % SZ;
    if (e_bm) begin
      mq.delete(); m_tail = m_head;
    end else begin
      for (int j = 0; j < W; j++)
        if (dup_req[j])
          foreach (mq[i]) if (mq[i].idx == int'(rob_idx_in[j])) begin
            mq[i].rdy = 1'b1; mq[i].btex = bt_ex_in[j]; mq[i].baex = ba_ex_in[j];
          end
      for (int k = 0; k < W; k++) if (e_gnt[k]) begin
        e.idx = m_tail; e.ir = ir_in[k]; e.npc = npc_in[k]; e.bapd = ba_pd_in[k]; e.baex = 64'd0;
        e.isbr = isbranch_in[k]; e.btpd = bt_pd_in[k]; e.ill = illegal_in[k];
        e.rdy = illegal_in[k]; e.btex = 1'b0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % SZ;
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < W; k++) begin
        din_req[k] = ($urandom_range(3, 0) != 0);
        ir_in[k] = $urandom(); npc_in[k] = {32'd0, $urandom()};
        pdest_in[k] = PI'($urandom()); adest_in[k] = AI'($urandom());
        isbranch_in[k] = ($urandom_range(3, 0) == 0); bt_pd_in[k] = 1'($urandom());
        ba_pd_in[k] = ($urandom_range(1, 0) == 0) ? 64'h100 : 64'h200;
        illegal_in[k] = ($urandom_range(15, 0) == 0);
        dup_req[k] = ($urandom_range(2, 0) != 0);
        if (mq.size() > 0 && $urandom_range(3, 0) != 0)
          rob_idx_in[k] = RI'(mq[$urandom_range(mq.size() - 1, 0)].idx);
        else rob_idx_in[k] = RI'($urandom());
        bt_ex_in[k] = 1'($urandom());
        ba_ex_in[k] = ($urandom_range(1, 0) == 0) ? 64'h100 : 64'h200;
      end
      model_expect();
      #2;
      checks += 8;
      if (din_gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, din_gnt, e_gnt); end
      if (dout_valid !== e_dv) begin failures++; $display("FAIL rnd_dv cyc=%0d got=%b exp=%b", cyc, dout_valid, e_dv); end
      if (branch_miss !== e_bm) begin failures++; $display("FAIL rnd_bm cyc=%0d got=%b exp=%b", cyc, branch_miss, e_bm); end
      if (correct_target !== e_ct) begin failures++; $display("FAIL rnd_ct cyc=%0d got=%h exp=%h", cyc, correct_target, e_ct); end
      if (head !== RI'(m_head)) begin failures++; $display("FAIL rnd_head cyc=%0d got=%0d exp=%0d", cyc, head, m_head); end
      if (free_cnt !== 6'(SZ - mq.size())) begin
        failures++; $display("FAIL rnd_free cyc=%0d got=%0d exp=%0d", cyc, free_cnt, SZ - mq.size()); end
      if (rob_idx_out[1] !== RI'((m_tail + 1) % SZ)) begin
        failures++; $display("FAIL rnd_idx cyc=%0d got=%0d exp=%0d", cyc, rob_idx_out[1], (m_tail + 1) % SZ); end
      if (e_dv[0] && (ir_out[0] !== mq[0].ir || illegal_out[0] !== mq[0].ill)) begin
        failures++; $display("FAIL rnd_fields cyc=%0d got=%h/%b exp=%h/%b", cyc, ir_out[0], illegal_out[0], mq[0].ir, mq[0].ill); end
      @(posedge clk);
      model_commit();
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fill();
    test_out_of_order();
    test_branch_slot1();
    test_branch_slot0();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
